// File: rtl/iob_uart16550_stream_defines.sv
// iob_uart16550_stream_defines: UART16550 register map, LSR bits, config values and FSM states
package iob_uart16550_stream_defines;
  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam int LSR_DR = 0;
  localparam int LSR_THRE = 5;
  localparam logic [7:0] LCR_DLAB = 8'h83;
  localparam logic [7:0] LCR_8N1 = 8'h03;
  localparam logic [7:0] FCR_CFG = 8'h07;
  localparam logic [7:0] IER_CFG = 8'h00;
  localparam int CFG_N = 6;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG       = 3'd1,
    POLL_REQ  = 3'd2,
    POLL_WAIT = 3'd3,
    RX_REQ    = 3'd4,
    RX_WAIT   = 3'd5,
    TX_WR     = 3'd6
  } state_t;
endpackage

// File: rtl/iob_uart16550_stream_cfg_rom.sv
// iob_uart16550_stream_cfg_rom: six-entry UART init table (register offset and byte per index)
//   idx  in  3  table index 0..5
//   div  in  16 latched baud divisor, feeds the DLL/DLM entries
//   addr out 3  register offset
//   data out 8  byte to write
module iob_uart16550_stream_cfg_rom
  import iob_uart16550_stream_defines::*;
(
  input  logic [2:0]  idx,
  input  logic [15:0] div,
  output logic [2:0]  addr,
  output logic [7:0]  data
);
  always_comb begin
    addr = idx == 3'd0 ? REG_LCR : idx == 3'd1 ? REG_DLL : idx == 3'd2 ? REG_DLM :
           idx == 3'd3 ? REG_LCR : idx == 3'd4 ? REG_FCR : REG_IER;
    data = idx == 3'd0 ? LCR_DLAB : idx == 3'd1 ? div[7:0] : idx == 3'd2 ? div[15:8] :
           idx == 3'd3 ? LCR_8N1 : idx == 3'd4 ? FCR_CFG : IER_CFG;
  end
endmodule

// File: rtl/iob_uart16550_stream.sv
// iob_uart16550_stream: IOb master that configures a UART16550 and bridges it to byte streams
//   clk_i/arst_n_i/cke_i      clock, async active-low reset, clock enable
//   start_i/stop_i/div_i      run control and baud divisor, busy_o high outside IDLE
//   tx_data_i/valid_i/ready_o TX byte stream into THR
//   rx_data_o/valid_o/ready_i RX byte stream out of RBR
//   iob_*                     IOb master port towards the UART register file
module iob_uart16550_stream
  import iob_uart16550_stream_defines::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int BURST = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [15:0]         div_i,
  output logic                busy_o,
  input  logic [7:0]          tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic [7:0]          rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);
  localparam int STRB_W = DATA_W / 8;
  localparam int BW = $clog2(BURST + 1);
  state_t st;
  logic [15:0] div_q;
  logic [2:0] cfg_idx;
  logic [BW-1:0] burst;
  logic stop_pend;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic [2:0] off;
  logic [1:0] rlane;
  logic [7:0] wbyte;
  logic [7:0] rbyte;
  logic wr;
  logic acc;
  logic stop_now;
  iob_uart16550_stream_cfg_rom u_rom (
    .idx (cfg_idx),
    .div (div_q),
    .addr(rom_addr),
    .data(rom_data)
  );
  // Request fields are decoded from the registered state, so they hold while a request waits.
  always_comb begin
    off = st == CFG ? rom_addr : st == POLL_REQ ? REG_LSR : 3'd0;
    wbyte = st == CFG ? rom_data : st == TX_WR ? tx_data_i : 8'd0;
    wr = st == CFG || st == TX_WR;
    rlane = st == POLL_WAIT ? REG_LSR[1:0] : REG_RBR[1:0];
    iob_valid_o = st == CFG || st == POLL_REQ || st == RX_REQ || (st == TX_WR && tx_valid_i);
    iob_addr_o = ADDR_W'(off);
    iob_wdata_o = {STRB_W{wbyte}};
    iob_wstrb_o = wr ? STRB_W'(1) << off[1:0] : '0;
    rbyte = iob_rdata_i[{rlane, 3'b000} +: 8];
    busy_o = st != IDLE;
    tx_ready_o = st == TX_WR && iob_ready_i;
    acc = iob_valid_o && iob_ready_i;
    stop_now = stop_pend || stop_i;
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      st <= IDLE;
      div_q <= '0;
      cfg_idx <= '0;
      burst <= '0;
      stop_pend <= 1'b0;
      rx_data_o <= '0;
      rx_valid_o <= 1'b0;
    end else if (cke_i) begin
      // A stop seen in IDLE (including alongside start) is discarded.
      stop_pend <= st != IDLE && stop_now;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      case (st)
        IDLE: if (start_i) begin
          div_q <= div_i;
          cfg_idx <= '0;
          st <= CFG;
        end
        CFG: if (acc) begin
          cfg_idx <= cfg_idx + 3'd1;
          if (stop_now || cfg_idx == 3'(CFG_N - 1)) st <= stop_now ? IDLE : POLL_REQ;
        end
        POLL_REQ: if (acc) st <= POLL_WAIT;
        POLL_WAIT: if (iob_rvalid_i) begin
          burst <= '0;
          st <= stop_now ? IDLE :
                rbyte[LSR_DR] && !rx_valid_o ? RX_REQ :
                rbyte[LSR_THRE] && tx_valid_i ? TX_WR : POLL_REQ;
        end
        RX_REQ: if (acc) st <= RX_WAIT;
        RX_WAIT: if (iob_rvalid_i) begin
          rx_data_o <= rbyte;
          rx_valid_o <= 1'b1;
          st <= stop_now ? IDLE : POLL_REQ;
        end
        TX_WR: begin
          burst <= burst + BW'(acc);
          if (!tx_valid_i || (acc && (stop_now || burst == BW'(BURST - 1))))
            st <= stop_now ? IDLE : POLL_REQ;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
